// File: rtl/des_pkg.sv
// DES key-schedule constants: PC-1/PC-2 tables, shift schedule,
// state encoding and the bit-level helpers shared by the key path.
package des_pkg;

  localparam int C_W   = 28;
  localparam int K_W   = 48;
  localparam int CD_W  = 56;
  localparam int KEY_W = 64;

  typedef enum logic {IDLE, RUN} state_t;

  // Entries use standard DES numbering: bit 1 is the MSB.
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Bit i set means round i+1 shifts by one; all others shift by two.
  localparam logic [15:0] SHIFT_ONE = 16'h8103;

  function automatic logic shift_one(input logic [3:0] i);
    return SHIFT_ONE[i];
  endfunction

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int j = 0; j < CD_W; j++)
      r[CD_W-1-j] = k[KEY_W-PC1_T[j]];
    return r;
  endfunction

  function automatic logic [C_W-1:0] rot(
    input logic [C_W-1:0] v,
    input logic           left,
    input logic           two
  );
    logic [C_W-1:0] r;
    unique case ({left, two})
      2'b10:   r = {v[C_W-2:0], v[C_W-1]};
      2'b11:   r = {v[C_W-3:0], v[C_W-1:C_W-2]};
      2'b00:   r = {v[0], v[C_W-1:1]};
      default: r = {v[1:0], v[C_W-1:2]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2: compresses the 56-bit C||D register pair
// into a 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0] i_cd,
  output logic [K_W-1:0]  o_k
);

  always_comb begin
    o_k = '0;
    for (int j = 0; j < K_W; j++)
      o_k[K_W-1-j] = i_cd[CD_W-PC2_T[j]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: streams K1..K16 (or K16..K1) one
// subkey per valid/ready transfer from a single loaded key.
module des_key_schedule
  import des_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_load,
  input  logic             decrypt,
  output logic             key_ready,
  output logic [K_W-1:0]   subkey,
  output logic             subkey_valid,
  input  logic             subkey_ready,
  output logic [3:0]       round,
  output logic             last
);

  state_t         r_state;
  logic [C_W-1:0] r_c;
  logic [C_W-1:0] r_d;
  logic           r_dec;
  logic [3:0]     r_round;
  logic [K_W-1:0] r_subkey;
  logic           r_valid;
  logic           r_last;
  logic           r_kready;

  logic [CD_W-1:0] w_pc1;
  logic [C_W-1:0]  w_src_c;
  logic [C_W-1:0]  w_src_d;
  logic [C_W-1:0]  w_next_c;
  logic [C_W-1:0]  w_next_d;
  logic [K_W-1:0]  w_pc2;
  logic [3:0]      w_idx;
  logic            w_left;
  logic            w_two;
  logic            w_norot;
  logic            w_load;
  logic            w_xfer;

  assign w_pc1  = pc1(key_in);
  assign w_load = key_load & (r_state == IDLE);
  assign w_xfer = r_valid & subkey_ready;

  // IDLE feeds C0/D0; RUN feeds the registers with the shift that
  // reaches the next subkey (left by s_{n+2}, or right by s_k).
  always_comb begin
    w_src_c = r_c;
    w_src_d = r_d;
    w_left  = ~r_dec;
    w_idx   = r_dec ? 4'd15 - r_round : r_round + 4'd1;
    w_norot = 1'b0;
    if (r_state == IDLE) begin
      w_src_c = w_pc1[CD_W-1:C_W];
      w_src_d = w_pc1[C_W-1:0];
      w_left  = 1'b1;
      w_idx   = 4'd0;
      w_norot = decrypt;
    end
    w_two    = ~shift_one(w_idx);
    w_next_c = w_norot ? w_src_c : rot(w_src_c, w_left, w_two);
    w_next_d = w_norot ? w_src_d : rot(w_src_d, w_left, w_two);
  end

  des_pc2 u_pc2 (
    .i_cd ({w_next_c, w_next_d}),
    .o_k  (w_pc2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_c      <= '0;
      r_d      <= '0;
      r_dec    <= 1'b0;
      r_round  <= '0;
      r_subkey <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_kready <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_load) begin
            r_state  <= RUN;
            r_c      <= w_next_c;
            r_d      <= w_next_d;
            r_dec    <= decrypt;
            r_subkey <= w_pc2;
            r_round  <= '0;
            r_valid  <= 1'b1;
            r_last   <= 1'b0;
            r_kready <= 1'b0;
          end
        end
        RUN: begin
          if (w_xfer) begin
            if (r_last) begin
              r_state  <= IDLE;
              r_valid  <= 1'b0;
              r_round  <= '0;
              r_last   <= 1'b0;
              r_kready <= 1'b1;
            end else begin
              r_c      <= w_next_c;
              r_d      <= w_next_d;
              r_subkey <= w_pc2;
              r_round  <= r_round + 4'd1;
              r_last   <= (r_round == 4'd14);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign key_ready    = r_kready;
  assign subkey       = r_subkey;
  assign subkey_valid = r_valid;
  assign round        = r_round;
  assign last         = r_last;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic
// 133457799BBCDFF1 key and its published round subkeys.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] key_in = '0;
  logic        key_load = 1'b0;
  logic        decrypt = 1'b0;
  logic        key_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready = 1'b0;
  logic [3:0]  round;
  logic        last;

  int checks = 0;
  int failures = 0;

  logic [47:0] ks [16];
  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P = 64'h123556789ABDDEF0;
  localparam logic [63:0] KEY_X = 64'h0123456789ABCDEF;

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .key_load     (key_load),
    .decrypt      (decrypt),
    .key_ready    (key_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round        (round),
    .last         (last)
  );

  always #5 clk = ~clk;

  // {valid, round, last, subkey}
  function automatic logic [53:0] pack_exp(input int idx, input logic dec);
    logic [3:0] r;
    r = idx[3:0];
    return {1'b1, r, (idx == 15), dec ? ks[15-idx] : ks[idx]};
  endfunction

  task automatic do_load(input logic [63:0] k, input logic d);
    @(negedge clk);
    key_in   = k;
    decrypt  = d;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({key_ready, subkey_valid, round, last, subkey} !== {1'b1, 1'b0, 4'd0, 1'b0, 48'd0}) begin
      failures++;
      $display("FAIL reset_state got kr=%b v=%b r=%0d l=%b k=%h", key_ready, subkey_valid, round, last, subkey);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_seq(input string nm, input logic [63:0] k, input logic d);
    logic [53:0] obs;
    subkey_ready = 1'b1;
    do_load(k, d);
    for (int i = 0; i < 16; i++) begin
      obs = {subkey_valid, round, last, subkey};
      checks++;
      if (obs !== pack_exp(i, d)) begin
        failures++;
        $display("FAIL %s_r%0d got %h want %h", nm, i, obs, pack_exp(i, d));
      end
      if (i == 0) begin
        checks++;
        if (key_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s_busy_ready got %b want 0", nm, key_ready);
        end
      end
      @(negedge clk);
    end
    checks++;
    if ({key_ready, subkey_valid} !== 2'b10) begin
      failures++;
      $display("FAIL %s_idle got kr=%b v=%b want kr=1 v=0", nm, key_ready, subkey_valid);
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int cyc = 0;
    int stalls = 0;
    logic [53:0] obs;
    subkey_ready = 1'b0;
    do_load(KEY_A, 1'b0);
    while (idx < 16 && cyc < 300) begin
      obs = {subkey_valid, round, last, subkey};
      checks++;
      if (obs !== pack_exp(idx, 1'b0)) begin
        failures++;
        $display("FAIL bp_t%0d got %h want %h", idx, obs, pack_exp(idx, 1'b0));
      end
      key_load = (cyc == 6 || cyc == 7);
      key_in   = KEY_X;
      decrypt  = 1'b1;
      subkey_ready = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      if (!subkey_ready) stalls++;
      if (subkey_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    key_load = 1'b0;
    subkey_ready = 1'b1;
    checks++;
    if (idx != 16 || stalls < 4) begin
      failures++;
      $display("FAIL bp_progress got idx=%0d stalls=%0d want 16 and >=4", idx, stalls);
    end
    checks++;
    if ({key_ready, subkey_valid} !== 2'b10) begin
      failures++;
      $display("FAIL bp_idle got kr=%b v=%b want kr=1 v=0", key_ready, subkey_valid);
    end
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    subkey_ready = 1'b1;
    do_load(KEY_A, 1'b0);
    while (n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (round !== 4'd8) begin
      failures++;
      $display("FAIL mid_pre_round got %0d want 8", round);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({key_ready, subkey_valid, round, last, subkey} !== {1'b1, 1'b0, 4'd0, 1'b0, 48'd0}) begin
      failures++;
      $display("FAIL mid_reset got kr=%b v=%b r=%0d l=%b k=%h", key_ready, subkey_valid, round, last, subkey);
    end
    @(negedge clk);
    rst = 1'b0;
    do_load(KEY_A, 1'b0);
    checks++;
    if ({subkey_valid, round, last, subkey} !== pack_exp(0, 1'b0)) begin
      failures++;
      $display("FAIL mid_restart got r=%0d k=%h want r=0 k=%h", round, subkey, ks[0]);
    end
    n = 0;
    while (subkey_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL mid_drain got %0d cycles want 16", n);
    end
  endtask

  task automatic test_back_to_back();
    logic [53:0] obs;
    @(negedge clk);
    subkey_ready = 1'b1;
    key_in   = KEY_A;
    decrypt  = 1'b0;
    key_load = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      obs = {subkey_valid, round, last, subkey};
      checks++;
      if (obs !== pack_exp(i, 1'b0)) begin
        failures++;
        $display("FAIL b2b_a_r%0d got %h want %h", i, obs, pack_exp(i, 1'b0));
      end
      if (i == 0) begin
        decrypt = 1'b1;
        key_in  = KEY_P;
      end
    end
    @(negedge clk);
    checks++;
    if ({key_ready, subkey_valid} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_gap got kr=%b v=%b want kr=1 v=0", key_ready, subkey_valid);
    end
    @(negedge clk);
    key_load = 1'b0;
    obs = {subkey_valid, round, last, subkey};
    checks++;
    if (obs !== pack_exp(0, 1'b1) || key_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_b_r0 got %h kr=%b want %h kr=0", obs, key_ready, pack_exp(0, 1'b1));
    end
    for (int i = 1; i < 16; i++) @(negedge clk);
    checks++;
    if ({subkey_valid, round, last, subkey} !== pack_exp(15, 1'b1)) begin
      failures++;
      $display("FAIL b2b_b_r15 got r=%0d l=%b k=%h want %h", round, last, subkey, ks[0]);
    end
    @(negedge clk);
  endtask

  initial begin
    ks[0]  = 48'h1B02EFFC7072;
    ks[1]  = 48'h79AED9DBC9E5;
    ks[2]  = 48'h55FC8A42CF99;
    ks[3]  = 48'h72ADD6DB351D;
    ks[4]  = 48'h7CEC07EB53A8;
    ks[5]  = 48'h63A53E507B2F;
    ks[6]  = 48'hEC84B7F618BC;
    ks[7]  = 48'hF78A3AC13BFB;
    ks[8]  = 48'hE0DBEBEDE781;
    ks[9]  = 48'hB1F347BA464F;
    ks[10] = 48'h215FD3DED386;
    ks[11] = 48'h7571F59467E9;
    ks[12] = 48'h97C5D1FABA41;
    ks[13] = 48'h5F43B7F2E73A;
    ks[14] = 48'hBF918D3D3F0A;
    ks[15] = 48'hCB3D8B0E17F5;
    test_reset();
    test_seq("enc", KEY_A, 1'b0);
    test_seq("dec", KEY_A, 1'b1);
    test_seq("parity", KEY_P, 1'b0);
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
